// File: rtl/pipe_skid_register.sv
// -----------------------------------------------------------------------------
// pipe_skid_register
//
// Multi-lane pipeline stage register with a valid/ready handshake, a one-entry
// skid buffer, a synchronous flush and per-lane valid masks. The stage carries
// LANES instruction slots per beat. It absorbs one beat of back-pressure so
// that in_ready comes purely from registered state, with no combinational
// path from out_ready.
//
// Parameters
//   WIDTH      bits per lane
//   LANES      slots per beat
//   RESET_VAL  value loaded into every data lane on reset or flush
//
// Ports
//   clock          in   rising-edge clock
//   ctrl_reset     in   asynchronous, active-low reset
//   ctrl_flush     in   synchronous flush (empties the stage at the next edge)
//   in_valid       in   upstream beat present
//   in_lane_mask   in   per-lane valid bits of the incoming beat
//   in_data        in   incoming beat, lane i at [i*WIDTH +: WIDTH]
//   in_ready       out  stage can accept a beat this cycle
//   out_valid      out  main entry holds a beat
//   out_lane_mask  out  lane mask of the main entry
//   out_data       out  data of the main entry
//   out_ready      in   downstream consumes this cycle
//   occupancy      out  entries held: 0, 1 or 2
// -----------------------------------------------------------------------------
module pipe_skid_register #(
  parameter int unsigned            WIDTH     = 32,
  parameter int unsigned            LANES     = 2,
  parameter logic [WIDTH-1:0]       RESET_VAL = '0
) (
  input  logic                      clock,
  input  logic                      ctrl_reset,
  input  logic                      ctrl_flush,
  input  logic                      in_valid,
  input  logic [LANES-1:0]          in_lane_mask,
  input  logic [WIDTH*LANES-1:0]    in_data,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [LANES-1:0]          out_lane_mask,
  output logic [WIDTH*LANES-1:0]    out_data,
  input  logic                      out_ready,
  output logic [1:0]                occupancy
);

  // The state encoding is the occupancy count itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  localparam logic [WIDTH*LANES-1:0] DATA_RESET = {LANES{RESET_VAL}};

  state_t                   state;
  state_t                   state_next;

  logic [WIDTH*LANES-1:0]   main_data;
  logic [LANES-1:0]         main_mask;
  logic [WIDTH*LANES-1:0]   skid_data;
  logic [LANES-1:0]         skid_mask;

  logic                     accept;
  logic                     drain;
  logic                     load_main_in;
  logic                     load_main_skid;
  logic                     load_skid_in;

  // Handshake outputs are decoded from the state register only.
  assign in_ready      = (state != TWO);
  assign out_valid     = (state != EMPTY);
  assign occupancy     = state;
  assign out_data      = main_data;
  assign out_lane_mask = main_mask;

  // A beat with an all-zero lane mask completes the handshake but is dropped,
  // so only non-bubble accepts move the FSM.
  assign accept = in_valid & in_ready & (|in_lane_mask);
  assign drain  = out_valid & out_ready;

  // NOTE: every output of this block is given a default first; without it a
  // path that skips an assignment would infer a latch.
  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;

    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_next   = ONE;
          load_main_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && drain) begin
          load_main_in = 1'b1;
        end else if (accept) begin
          state_next   = TWO;
          load_skid_in = 1'b1;
        end else if (drain) begin
          state_next   = EMPTY;
        end
      end
      TWO: begin
        // in_ready is low here, so only a drain can happen.
        if (drain) begin
          state_next     = ONE;
          load_main_skid = 1'b1;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase

    // Flush overrides everything: any accepted beat is dropped, while a drain
    // in the same cycle has already completed downstream.
    if (ctrl_flush) begin
      state_next     = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: both entries are reset, not just the state, because out_data must
  // read RESET_VAL and out_lane_mask must read zero straight out of reset.
  always_ff @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      main_data <= DATA_RESET;
      main_mask <= '0;
      skid_data <= DATA_RESET;
      skid_mask <= '0;
    end else if (ctrl_flush) begin
      main_data <= DATA_RESET;
      main_mask <= '0;
      skid_data <= DATA_RESET;
      skid_mask <= '0;
    end else begin
      if (load_main_in) begin
        main_data <= in_data;
        main_mask <= in_lane_mask;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_mask <= skid_mask;
      end
      if (load_skid_in) begin
        skid_data <= in_data;
        skid_mask <= in_lane_mask;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_register.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_register
//
// Self-checking bench for pipe_skid_register (WIDTH=32, LANES=2,
// RESET_VAL=0). A queue model holds the beats that must be in the stage; a
// compare process checks the DUT against it on every falling edge, and the
// directed sequence adds hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_pipe_skid_register;

  localparam int WIDTH = 32;
  localparam int LANES = 2;
  localparam logic [WIDTH-1:0] RESET_VAL = '0;

  logic                   clock;
  logic                   ctrl_reset;
  logic                   ctrl_flush;
  logic                   in_valid;
  logic [LANES-1:0]       in_lane_mask;
  logic [WIDTH*LANES-1:0] in_data;
  logic                   in_ready;
  logic                   out_valid;
  logic [LANES-1:0]       out_lane_mask;
  logic [WIDTH*LANES-1:0] out_data;
  logic                   out_ready;
  logic [1:0]             occupancy;

  pipe_skid_register #(
    .WIDTH     (WIDTH),
    .LANES     (LANES),
    .RESET_VAL (RESET_VAL)
  ) dut (
    .clock         (clock),
    .ctrl_reset    (ctrl_reset),
    .ctrl_flush    (ctrl_flush),
    .in_valid      (in_valid),
    .in_lane_mask  (in_lane_mask),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_lane_mask (out_lane_mask),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .occupancy     (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Model: an ordered list of the beats the stage holds (at most two).
  // 'fresh' is set while outputs must still show the reset/flush values.
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [WIDTH*LANES-1:0] data;
    logic [LANES-1:0]       mask;
  } beat_t;

  beat_t q[$];
  bit    fresh = 1'b1;
  bit    check_en = 1'b0;

  always @(posedge clock or negedge ctrl_reset) begin
    if (!ctrl_reset) begin
      q.delete();
      fresh = 1'b1;
    end else begin
      bit acc;
      bit dr;
      acc = in_valid && (q.size() < 2);
      dr  = (q.size() > 0) && out_ready;
      if (ctrl_flush) begin
        q.delete();
        fresh = 1'b1;
      end else begin
        if (dr) void'(q.pop_front());
        if (acc && (in_lane_mask != '0)) begin
          q.push_back('{data: in_data, mask: in_lane_mask});
          fresh = 1'b0;
        end
      end
    end
  end

  always @(negedge clock) begin
    if (check_en) begin
      check("m_in_ready",  {63'd0, in_ready},  {63'd0, q.size() < 2});
      check("m_out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
      check("m_occupancy", {62'd0, occupancy}, 64'(q.size()));
      if (q.size() != 0) begin
        check("m_out_data", out_data, q[0].data);
        check("m_out_mask", {62'd0, out_lane_mask}, {62'd0, q[0].mask});
      end else if (fresh) begin
        check("m_out_data_rst", out_data, {LANES{RESET_VAL}});
        check("m_out_mask_rst", {62'd0, out_lane_mask}, 64'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after a falling edge, so they
  // are stable at the rising edge and the compare process has already run.
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] m,
                       input logic [31:0] lane1, input logic [31:0] lane0);
    in_valid     = v;
    in_lane_mask = m;
    in_data      = {lane1, lane0};
  endtask

  initial begin
    ctrl_reset = 1'b0;
    ctrl_flush = 1'b0;
    out_ready  = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    check_en   = 1'b1;
    tick();

    // Reset state.
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    check("rst_occupancy", {62'd0, occupancy}, 64'd0);
    check("rst_out_data",  out_data, 64'd0);
    tick();
    ctrl_reset = 1'b1;
    tick();

    // Streaming: (1,2) .. (15,16) with out_ready high.
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 2'b11, 32'(2*k + 2), 32'(2*k + 1));
      tick();
      if (k == 0) check("stream_first", out_data, {32'd2, 32'd1});
    end
    check("stream_last", out_data, {32'd16, 32'd15});
    check("stream_occ",  {62'd0, occupancy}, 64'd1);
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    tick();
    check("stream_empty", {63'd0, out_valid}, 64'd0);

    // Partial lanes: masked-off lane data passes through.
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 32'hDEAD, 32'h1234);
    tick();
    check("partial_mask", {62'd0, out_lane_mask}, 64'd1);
    check("partial_data", out_data, {32'hDEAD, 32'h1234});

    // Bubble while in ONE: handshake completes, nothing changes.
    drive(1'b1, 2'b00, 32'h5555, 32'h6666);
    check("bubble_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check("bubble_occ",  {62'd0, occupancy}, 64'd1);
    check("bubble_data", out_data, {32'hDEAD, 32'h1234});
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    out_ready = 1'b1;
    tick();

    // Back-pressure: A, B accepted, C held upstream.
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 32'hA1, 32'hA0);
    tick();
    drive(1'b1, 2'b11, 32'hB1, 32'hB0);
    tick();
    check("bp_occ2",  {62'd0, occupancy}, 64'd2);
    check("bp_ready0", {63'd0, in_ready}, 64'd0);
    drive(1'b1, 2'b11, 32'hC1, 32'hC0);
    tick();
    check("bp_hold_occ", {62'd0, occupancy}, 64'd2);
    check("bp_out_A",    out_data, {32'hA1, 32'hA0});
    out_ready = 1'b1;
    tick();
    check("bp_out_B",   out_data, {32'hB1, 32'hB0});
    check("bp_ready1",  {63'd0, in_ready}, 64'd1);
    tick();
    check("bp_out_C",   out_data, {32'hC1, 32'hC0});
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    tick();
    check("bp_drained", {62'd0, occupancy}, 64'd0);

    // Flush with occupancy 2 and an input beat present.
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 32'hD1, 32'hD0);
    tick();
    drive(1'b1, 2'b11, 32'hE1, 32'hE0);
    tick();
    drive(1'b1, 2'b11, 32'hF1, 32'hF0);
    ctrl_flush = 1'b1;
    tick();
    ctrl_flush = 1'b0;
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    check("flush_occ",   {62'd0, occupancy}, 64'd0);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    check("flush_mask",  {62'd0, out_lane_mask}, 64'd0);
    check("flush_data",  out_data, 64'd0);
    out_ready = 1'b1;
    tick();
    tick();
    check("flush_no_F", {63'd0, out_valid}, 64'd0);

    // Flush coinciding with a drain from ONE.
    drive(1'b1, 2'b10, 32'h77, 32'h88);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    ctrl_flush = 1'b1;
    tick();
    ctrl_flush = 1'b0;
    check("flush_drain_occ", {62'd0, occupancy}, 64'd0);

    // Asynchronous reset mid-cycle with occupancy 2.
    out_ready = 1'b0;
    drive(1'b1, 2'b11, 32'h91, 32'h90);
    tick();
    drive(1'b1, 2'b11, 32'h93, 32'h92);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    check("arst_pre_occ", {62'd0, occupancy}, 64'd2);
    #1;
    ctrl_reset = 1'b0;
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_occ",   {62'd0, occupancy}, 64'd0);
    check("arst_ready", {63'd0, in_ready},  64'd1);
    check("arst_data",  out_data, 64'd0);
    check("arst_mask",  {62'd0, out_lane_mask}, 64'd0);
    tick();
    ctrl_reset = 1'b1;
    drive(1'b1, 2'b11, 32'h22, 32'h11);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0);
    check("arst_first_valid", {63'd0, out_valid}, 64'd1);
    check("arst_first_data",  out_data, {32'h22, 32'h11});
    out_ready = 1'b1;
    tick();
    tick();

    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_register.md
# pipe_skid_register

Parametrised successor to the plain 32-bit enable register: a multi-lane pipeline stage register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and per-lane valid masks. It sits between stages of the 2-wide pipeline, such as fetch→decode and decode→execute. It carries LANES instruction slots per beat and absorbs one beat of back-pressure without a combinational ready path from the downstream stage to the upstream stage.

## Interface
- WIDTH, 32, bits per lane.
- LANES, 2, slots per beat.
- RESET_VAL, 0, value loaded into every lane's data on reset or flush (WIDTH bits).

- clock  in  1  rising-edge clock.
- ctrl_reset  in  1  reset; asynchronous and active-low.
- ctrl_flush  in  1  synchronous flush; highest priority after reset.
- in_valid  in  1  upstream beat present.
- in_lane_mask  in  LANES  per-lane valid bits of the incoming beat.
- in_data  in  WIDTH*LANES  lane i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  1  stage can accept a beat this cycle.
- out_valid  out  1  main entry holds a beat.
- out_lane_mask  out  LANES  lane mask of the main entry.
- out_data  out  WIDTH*LANES  data of the main entry.
- out_ready  in  1  downstream consumes this cycle.
- occupancy  out  2  entries held: 0, 1 or 2.

## Operation
- Storage is two entries, main and skid. Each entry holds data and a lane mask.
- State is held as occupancy. The states are EMPTY (0), ONE (1) and TWO (2).
- Accept means in_valid & in_ready. Drain means out_valid & out_ready.
- in_ready = (state != TWO). It is decoded from the state register only.
- out_valid = (state != EMPTY). out_data and out_lane_mask are driven directly from the main entry.
- Bubble rule: an accepted beat with in_lane_mask == 0 completes the handshake but is discarded. State and entries do not change.
- Transitions, for non-bubble accepts with no flush:
  - EMPTY, accept: go to ONE; main <= in.
  - ONE, accept and drain: stay in ONE; main <= in.
  - ONE, accept and no drain: go to TWO; skid <= in.
  - ONE, drain only: go to EMPTY.
  - TWO, drain: go to ONE; main <= skid. Accept cannot occur because in_ready = 0.
  - Any state with neither accept nor drain: hold.
- Flush: at the next edge, state goes to EMPTY. Both entries' masks go to 0 and all data lanes go to RESET_VAL.
  - A beat accepted in the flush cycle is dropped.
  - A drain in the flush cycle still counts as a completed transfer downstream.
- Reset: while ctrl_reset = 0, the block is asynchronously forced to the following:
  - state EMPTY, occupancy 0;
  - out_valid 0, in_ready 1;
  - out_lane_mask 0;
  - out_data = RESET_VAL in every lane;
  - skid entry cleared the same way.
- Ordering: beats leave in acceptance order. No beat is duplicated or lost except by flush or the bubble rule.
- Lanes are not reordered or compacted. Lane i in gives lane i out, and masked-off lanes' data passes through unchanged.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on out_* after edge N.
- Throughput is 1 beat per cycle with out_ready held high. Occupancy stays at 1 in that steady state.
- in_ready depends only on registered state. There is no combinational path from out_ready or in_valid to in_ready.
- out_* are pure register outputs.
- When out_valid = 0, out_data is don't-care, except that it equals RESET_VAL immediately after reset or flush.
- Reset deassertion is assumed synchronous to clock at the system level. The first accept can occur at the first edge after deassertion.

## Test plan
- Async reset: assert ctrl_reset = 0 mid-cycle with occupancy 2 → without waiting for a clock edge:
  - out_valid = 0, occupancy = 0, in_ready = 1;
  - out_data = 0 with RESET_VAL = 0;
  - after release, an accept of 0x11/0x22 appears on the next cycle.
- Streaming: in_valid = 1, mask 2'b11, data pairs (1,2), (3,4) … (15,16), out_ready = 1 → outputs appear in the same order one cycle later, occupancy stays at 1, and no cycle has in_ready = 0.
- Back-pressure:
  - Hold out_ready = 0 and push beats A, B, C → A and B are accepted, occupancy = 2, in_ready = 0, and C is held upstream.
  - Raise out_ready → output order is A, B, C; in_ready returns to 1 one cycle after the first drain.
- Flush: with occupancy 2 and in_valid = 1, pulse ctrl_flush for one cycle → on the next cycle occupancy = 0, out_valid = 0 and out_lane_mask = 0; the input beat never appears.
- Bubble: in_valid = 1 with in_lane_mask = 2'b00 while in ONE → handshake completes, occupancy remains 1 and out_data is unchanged.
- Partial lanes: accept mask 2'b01 with data lane0 = 0x1234, lane1 = 0xDEAD → out_lane_mask = 2'b01, lane0 = 0x1234, lane1 = 0xDEAD passed through unchanged.
